// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port between the instruction
// fetch stage and the data memory stage. Data requests take priority. A branch
// flush cancels a pending fetch grant or suppresses the done pulse of an
// in-flight fetch. The memory transaction itself always runs to completion.
module mem_arbiter #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        flush,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  // data port
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  // memory side
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             kill;
  logic             last;

  // Arbitration FSM, busy counter, fetch kill flag and latched memory command.
  // mem_en is set on the grant edge so it is high exactly while cnt==LATENCY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      kill      <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_req) begin
            state     <= BUSY_D;
            cnt       <= CNT_LOAD;
            mem_en    <= 1'b1;
            mem_wr    <= dm_wr;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (if_req && !flush) begin
            state    <= BUSY_I;
            cnt      <= CNT_LOAD;
            kill     <= 1'b0;
            mem_en   <= 1'b1;
            mem_wr   <= 1'b0;
            mem_addr <= if_addr;
          end
        end
        BUSY_I: begin
          if (flush) begin
            kill <= 1'b1;
          end
          cnt <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            state <= IDLE;
          end
        end
        BUSY_D: begin
          cnt <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Completion pulses and returned data, decoded from the current busy state.
  always_comb begin
    last     = (cnt == CNT_LAST);
    if_done  = (state == BUSY_I) && last && !kill && !flush;
    dm_done  = (state == BUSY_D) && last;
    if_rdata = if_done ? mem_rdata : 16'h0000;
    dm_rdata = (dm_done && !mem_wr) ? mem_rdata : 16'h0000;
    if_stall = if_req & ~if_done;
    dm_stall = dm_req & ~dm_done;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by constrained random
// traffic, all checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, flush, dm_req, dm_wr;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr;

  mem_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Transaction-level model: who owns the memory, how many cycles of the
  // transaction have elapsed (1 = the start cycle), and the command in flight.
  int          m_owner;   // 0 none, 1 fetch, 2 data
  int          m_age;
  bit          m_kill;
  logic        m_wr;
  logic [15:0] m_addr, m_wdata;

  logic        exp_if_done, exp_dm_done;
  logic [15:0] obs_if_rdata, obs_dm_rdata, obs_mem_addr;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs already applied at the falling edge.
  task automatic cyc();
    bit          busy, fin, e_en, e_if, e_dm;
    logic [15:0] e_ird, e_drd;
    #1;
    busy  = (m_owner != 0);
    fin   = busy && (m_age == LAT);
    e_en  = busy && (m_age == 1);
    e_if  = (m_owner == 1) && fin && !m_kill && !flush;
    e_dm  = (m_owner == 2) && fin;
    e_ird = e_if ? mem_rdata : 16'h0000;
    e_drd = (e_dm && !m_wr) ? mem_rdata : 16'h0000;
    chk("mem_en",    16'(mem_en),   16'(e_en));
    chk("mem_wr",    16'(mem_wr),   16'(m_wr));
    chk("mem_addr",  mem_addr,      m_addr);
    chk("mem_wdata", mem_wdata,     m_wdata);
    chk("if_done",   16'(if_done),  16'(e_if));
    chk("if_rdata",  if_rdata,      e_ird);
    chk("if_stall",  16'(if_stall), 16'(if_req && !e_if));
    chk("dm_done",   16'(dm_done),  16'(e_dm));
    chk("dm_rdata",  dm_rdata,      e_drd);
    chk("dm_stall",  16'(dm_stall), 16'(dm_req && !e_dm));
    exp_if_done  = e_if;
    exp_dm_done  = e_dm;
    obs_if_rdata = if_rdata;
    obs_dm_rdata = dm_rdata;
    obs_mem_addr = mem_addr;
    // advance the model to the next cycle
    if (rst) begin
      m_owner = 0; m_age = 0; m_kill = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
    end else if (!busy) begin
      if (dm_req) begin
        m_owner = 2; m_age = 1; m_wr = dm_wr; m_addr = dm_addr; m_wdata = dm_wdata;
      end else if (if_req && !flush) begin
        m_owner = 1; m_age = 1; m_wr = 0; m_addr = if_addr; m_kill = 0;
      end
    end else begin
      if (m_owner == 1 && flush) m_kill = 1;
      if (fin) begin
        m_owner = 0; m_age = 0;
      end else begin
        m_age++;
      end
    end
    @(negedge clk);
  endtask

  // Run until the fetch (or data) completes; returns cycles used, bounded.
  task automatic run_until_if(output int n);
    n = 0;
    do begin cyc(); n++; end while (!exp_if_done && n < 40);
  endtask

  task automatic run_until_dm(output int n);
    n = 0;
    do begin cyc(); n++; end while (!exp_dm_done && n < 40);
  endtask

  initial begin
    int n;
    rst = 1; if_req = 0; if_addr = 0; flush = 0;
    dm_req = 0; dm_wr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    m_owner = 0; m_age = 0; m_kill = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
    repeat (2) @(negedge clk);
    rst = 0;

    // reset state
    cyc();
    chk("reset_mem_addr", mem_addr, 16'h0000);

    // fetch only
    if_req = 1; if_addr = 16'h0010; mem_rdata = 16'h1234;
    run_until_if(n);
    chk("fetch_latency", 16'(n), 16'(LAT + 1));
    chk("fetch_rdata", obs_if_rdata, 16'h1234);
    chk("fetch_addr", obs_mem_addr, 16'h0010);
    if_req = 0;
    cyc();

    // write
    dm_req = 1; dm_wr = 1; dm_addr = 16'h0100; dm_wdata = 16'hBEEF; mem_rdata = 16'h5A5A;
    run_until_dm(n);
    chk("write_latency", 16'(n), 16'(LAT + 1));
    chk("write_rdata", obs_dm_rdata, 16'h0000);
    dm_req = 0; dm_wr = 0;
    cyc();

    // simultaneous requests: data first, fetch after one idle cycle
    dm_req = 1; dm_addr = 16'h0200; if_req = 1; if_addr = 16'h0020; mem_rdata = 16'hC0DE;
    run_until_dm(n);
    chk("simul_dm_latency", 16'(n), 16'(LAT + 1));
    chk("simul_dm_rdata", obs_dm_rdata, 16'hC0DE);
    dm_req = 0;
    run_until_if(n);
    chk("simul_if_after_dm", 16'(n), 16'(LAT + 1));
    chk("simul_if_addr", obs_mem_addr, 16'h0020);
    if_req = 0;
    cyc();

    // flush in the 2nd busy cycle of a fetch, then redirect
    if_req = 1; if_addr = 16'h0030;
    cyc();              // grant
    cyc();              // 1st busy
    flush = 1;
    cyc();              // 2nd busy, flushed
    flush = 0; if_addr = 16'h0040;
    run_until_if(n);
    chk("flush_refetch_cycles", 16'(n), 16'(2 * LAT - 1));
    chk("flush_refetch_addr", obs_mem_addr, 16'h0040);
    if_req = 0;
    cyc();

    // reset in the 3rd busy cycle of a data read, request held
    dm_req = 1; dm_wr = 0; dm_addr = 16'h0300; mem_rdata = 16'h7777;
    cyc(); cyc(); cyc();
    rst = 1;
    cyc();
    rst = 0;
    cyc();              // idle after reset; held request granted here
    chk("rst_mid_addr", obs_mem_addr, 16'h0000);
    run_until_dm(n);
    chk("rst_regrant_latency", 16'(n), 16'(LAT));
    dm_req = 0;
    cyc();

    // random traffic obeying the request/hold protocol
    for (int i = 0; i < 600; i++) begin
      if (dm_req && exp_dm_done) dm_req = 0;
      if (if_req && exp_if_done) if_req = 0;
      if (!dm_req && ($urandom_range(3) == 0)) begin
        dm_req = 1; dm_wr = 1'($urandom); dm_addr = 16'($urandom); dm_wdata = 16'($urandom);
      end
      if (!if_req && ($urandom_range(2) == 0)) begin
        if_req = 1; if_addr = 16'($urandom);
      end
      if (flush) if_addr = 16'($urandom);
      flush = ($urandom_range(7) == 0);
      rst = ($urandom_range(99) == 0);
      mem_rdata = 16'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
